// File: rtl/seg7_pkg.sv
// Shared types, constants and glyph table for the seven-segment display blocks.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } seg7_state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low gfedcba patterns for a common-anode display.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-glyph decoder (active-low gfedcba).
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb glyph = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex driver for common-anode 7-segment banks with dead time and
// frame-synchronous capture. Define SEG7_DIMMING_EN for the brightness port and PWM dimming.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned SHOW_TICKS  = 100000,
  parameter int unsigned BLANK_TICKS = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   digit_en,
`ifdef SEG7_DIMMING_EN
  input  logic [3:0]            brightness,
`endif
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int unsigned MAX_TICKS = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int unsigned CW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int unsigned IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  if (N_DIGITS < 2 || SHOW_TICKS < 1) begin : g_param_check
    $error("seg7_scan_ctrl: N_DIGITS must be >= 2 and SHOW_TICKS >= 1");
  end

`ifdef SEG7_DIMMING_EN
  localparam int unsigned DIM_SLICE = SHOW_TICKS / 16;
  if (SHOW_TICKS % 16 != 0) begin : g_dim_check
    $error("seg7_scan_ctrl: SHOW_TICKS must be a multiple of 16 with dimming");
  end
  logic [3:0] sbr_q, sbr_d;
`endif

  seg7_state_t             state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   sdata_q, sdata_d;
  logic [N_DIGITS-1:0]     sdp_q, sdp_d;
  logic [N_DIGITS-1:0]     sen_q, sen_d;
  logic [N_DIGITS-1:0]     an_d;
  logic [7:0]              seg_d;
  logic                    tick_d;
  logic                    capture;
  logic                    lit;
  logic [3:0]              nibble;
  logic [6:0]              glyph;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sdata_d = sdata_q;
    sdp_d   = sdp_q;
    sen_d   = sen_q;
`ifdef SEG7_DIMMING_EN
    sbr_d   = sbr_q;
`endif
    tick_d  = 1'b0;
    capture = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          capture = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          if (BLANK_TICKS == 0) state_d = SHOW;
          else                  state_d = BLANK;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (BLANK_TICKS == 0) state_d = SHOW;
            else                  state_d = BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              tick_d  = 1'b1;
              capture = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (capture) begin
      sdata_d = data;
      sdp_d   = dp;
      sen_d   = digit_en;
`ifdef SEG7_DIMMING_EN
      sbr_d   = brightness;
`endif
    end
  end

  // Outputs decode the next-state values so the pins switch on the state-entry edge.
  assign nibble = sdata_d[{idx_d, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble (nibble),
    .glyph  (glyph)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    lit   = (state_d == SHOW) && sen_d[idx_d];
`ifdef SEG7_DIMMING_EN
    lit   = lit && (32'(cnt_d) < (32'(sbr_d) + 32'd1) * DIM_SLICE);
`endif
    if (lit) begin
      an_d[idx_d] = 1'b0;
      seg_d       = {~sdp_d[idx_d], glyph};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sdata_q    <= '0;
      sdp_q      <= '0;
      sen_q      <= '0;
`ifdef SEG7_DIMMING_EN
      sbr_q      <= '0;
`endif
      an         <= '1;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sdata_q    <= sdata_d;
      sdp_q      <= sdp_d;
      sen_q      <= sen_d;
`ifdef SEG7_DIMMING_EN
      sbr_q      <= sbr_d;
`endif
      an         <= an_d;
      seg        <= seg_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scan/blank/reset checks plus random stimulus against a
// cycle-position reference model, for BLANK_TICKS = 4 and BLANK_TICKS = 0 instances.
module tb_seg7_scan_ctrl;

  localparam int unsigned S  = 32;
  localparam int unsigned ND = 4;
  localparam int unsigned BT [2] = '{4, 0};
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
`ifdef SEG7_DIMMING_EN
  logic [3:0]  brightness;
`endif
  logic [3:0]  an0, an1;
  logic [7:0]  seg0, seg1;
  logic        tick0, tick1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.N_DIGITS(ND), .SHOW_TICKS(S), .BLANK_TICKS(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data(data), .dp(dp), .digit_en(digit_en),
`ifdef SEG7_DIMMING_EN
    .brightness(brightness),
`endif
    .an(an0), .seg(seg0), .frame_tick(tick0)
  );

  seg7_scan_ctrl #(.N_DIGITS(ND), .SHOW_TICKS(S), .BLANK_TICKS(0)) dut_nb (
    .clk(clk), .rst(rst), .enable(enable), .data(data), .dp(dp), .digit_en(digit_en),
`ifdef SEG7_DIMMING_EN
    .brightness(brightness),
`endif
    .an(an1), .seg(seg1), .frame_tick(tick1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: k counts edges since scanning started; everything else is arithmetic on k.
  bit          run [2];
  int unsigned mk  [2];
  logic [15:0] md  [2];
  logic [3:0]  mdp [2];
  logic [3:0]  men [2];
`ifdef SEG7_DIMMING_EN
  logic [3:0]  mbr [2];
`endif

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        run[m] = 1'b0; mk[m] = 0; md[m] = '0; mdp[m] = '0; men[m] = '0;
`ifdef SEG7_DIMMING_EN
        mbr[m] = '0;
`endif
      end else if (!enable) begin
        run[m] = 1'b0;
        mk[m]  = 0;
      end else begin
        if (!run[m]) begin
          run[m] = 1'b1;
          mk[m]  = 0;
        end else begin
          mk[m]++;
        end
        if (mk[m] % (ND * (BT[m] + S)) == 0) begin
          md[m] = data; mdp[m] = dp; men[m] = digit_en;
`ifdef SEG7_DIMMING_EN
          mbr[m] = brightness;
`endif
        end
      end
    end
  end

  function automatic void expect_out(input int m, output logic [3:0] a, output logic [7:0] s,
                                     output logic t);
    int unsigned per, pos, slot, off;
    bit lit;
    a = '1; s = 8'hFF; t = 1'b0;
    if (!run[m]) return;
    per  = BT[m] + S;
    pos  = mk[m] % (ND * per);
    slot = pos / per;
    off  = pos % per;
    t    = (mk[m] != 0) && (pos == 0);
    lit  = (off >= BT[m]) && men[m][slot];
`ifdef SEG7_DIMMING_EN
    lit  = lit && ((off - BT[m]) < (int'(mbr[m]) + 1) * (S / 16));
`endif
    if (lit) begin
      a[slot] = 1'b0;
      s = {~mdp[m][slot], GLYPH[md[m][slot*4 +: 4]]};
    end
  endfunction

  always @(negedge clk) begin
    logic [3:0] ea;
    logic [7:0] es;
    logic       et;
    expect_out(0, ea, es, et);
    check("an_b4", 32'(an0), 32'(ea));
    check("seg_b4", 32'(seg0), 32'(es));
    check("tick_b4", 32'(tick0), 32'(et));
    expect_out(1, ea, es, et);
    check("an_b0", 32'(an1), 32'(ea));
    check("seg_b0", 32'(seg1), 32'(es));
    check("tick_b0", 32'(tick1), 32'(et));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an0"}, 32'(an0), 32'hF);
    check({tag, "_seg0"}, 32'(seg0), 32'hFF);
    check({tag, "_an1"}, 32'(an1), 32'hF);
    check({tag, "_seg1"}, 32'(seg1), 32'hFF);
  endtask

  initial begin
    bit found;
    int unsigned r;
    rst = 1'b0; enable = 1'b0; data = 16'h1A2F; dp = 4'b0100; digit_en = 4'hF;
`ifdef SEG7_DIMMING_EN
    brightness = 4'hF;
`endif
    #1 rst = 1'b1;
    step(3);
    check_dark("reset");
    check("reset_tick", 32'(tick0), 32'h0);
    rst = 1'b0;
    step(1);
    enable = 1'b1;

    // Scan order, DP, then data/blank changes that must wait for the frame boundary.
    step(5);                                   // k = 4
    check("first_an", 32'(an0), 32'b1110);
    check("first_seg", 32'(seg0), 32'h8E);
    check("nb_first_seg", 32'(seg1), 32'h8E);
    step(36);                                  // k = 40
    check("d1_an", 32'(an0), 32'b1101);
    check("d1_seg", 32'(seg0), 32'hA4);
    check("nb_d1_an", 32'(an1), 32'b1101);
    step(36);                                  // k = 76
    check("d2_an", 32'(an0), 32'b1011);
    check("d2_seg_dp", 32'(seg0), 32'h08);
    data = 16'h0000;
    digit_en = 4'b1011;
    step(36);                                  // k = 112
    check("d3_old_seg", 32'(seg0), 32'hF9);
    check("d3_an", 32'(an0), 32'b0111);
    step(16);                                  // k = 128
    check("nb_frame_tick", 32'(tick1), 32'h1);
    step(16);                                  // k = 144
    check("frame_tick", 32'(tick0), 32'h1);
    step(4);                                   // k = 148
    check("new_seg", 32'(seg0), 32'hC0);
    check("new_an", 32'(an0), 32'b1110);
    step(72);                                  // k = 220
    check("blank_d2_an", 32'(an0), 32'hF);
    check("blank_d2_seg", 32'(seg0), 32'hFF);

    // Disable during SHOW of digit 1, then restart from digit 0.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1);
      if (run[0] && (mk[0] % 144 == 50)) found = 1'b1;
    end
    check("wait_d1_show", 32'(found), 32'h1);
    enable = 1'b0;
    step(1);
    check_dark("disable");
    enable = 1'b1;
    step(5);
    check("reenable_an", 32'(an0), 32'b1110);
    check("reenable_seg", 32'(seg0), 32'hC0);

    // Asynchronous reset during the dead time before digit 1.
    step(34);                                  // k = 38
    #2 rst = 1'b1;
    #1 check_dark("async_rst");
    @(negedge clk) rst = 1'b0;
    step(5);
    check("post_rst_an", 32'(an0), 32'b1110);

    // Random stimulus; the negedge monitor compares every cycle against the model.
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 999);
      if (r < 20) data = 16'($urandom);
      if (r >= 20 && r < 30) dp = 4'($urandom);
      if (r >= 30 && r < 40) digit_en = 4'($urandom) | 4'($urandom);
`ifdef SEG7_DIMMING_EN
      if (r >= 40 && r < 50) brightness = 4'($urandom);
`endif
      if (enable && r == 500) enable = 1'b0;
      else if (!enable && r < 100) enable = 1'b1;
      if (r == 999) begin
        #2 rst = 1'b1;
        #1 check_dark("rand_rst");
        @(negedge clk) rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
